// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive lane.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] LF         = 8'h0A;
  localparam int         OVERSAMPLE = 16;
  localparam int         MID_SAMPLE = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_push_ok,
  output logic             o_pop_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign o_empty   = (wr_ptr == rd_ptr);
  assign o_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_pop_ok  = i_pop && !o_empty;
  // a pop frees the head slot in the same cycle, so a full FIFO still accepts
  assign o_push_ok = i_push && (!o_full || o_pop_ok);
  assign o_data    = mem[rd_ptr[AW-1:0]];

  // storage and pointer update
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (o_push_ok) begin
        mem[wr_ptr[AW-1:0]] <= i_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (o_pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling 8N1 receiver feeding a show-ahead byte FIFO with LF tracking.
//
// state | meaning
// IDLE  | line idle, prescaler held; waiting for a synchronized falling edge
// START | counting to mid start bit; line high there means glitch
// DATA  | sampling 8 data bits LSB first, one per 16 ticks
// STOP  | sampling stop bit; push on 1, framing error on 0
module uart_rx_fifo #(
  parameter int DIV_SLOW = 325,
  parameter int DIV_FAST = 27,
  parameter int DEPTH    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_baud,
  input  logic       i_read,
  output logic [7:0] o_D,
  output logic       o_ready,
  output logic       o_used,
  output logic       o_full,
  output logic       o_err
);

  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 16;
  localparam int TW = $clog2(OVERSAMPLE);

  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       state, state_nx;
  logic [PW-1:0]   presc, div_q;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            fall, tick, mid_hit, bit_end;
  logic            push_req, frame_err, shift_en;
  logic [7:0]      head;
  logic            empty, full, push_ok, pop_ok;
  logic [AW:0]     lf_cnt;
  logic            lf_inc, lf_dec;
  logic            err_q;

  assign fall    = rx_prev && !rx_s2;
  assign tick    = (state != IDLE) && (presc == div_q - PW'(1));
  assign mid_hit = tick && (tick_cnt == TW'(MID_SAMPLE - 1));
  assign bit_end = tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  // two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // deframer state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // deframer next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fall) state_nx = START;
      START:   if (mid_hit) state_nx = rx_s2 ? IDLE : DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
      STOP:    if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // deframer outputs
  always_comb begin
    push_req  = 1'b0;
    frame_err = 1'b0;
    shift_en  = 1'b0;
    case (state)
      DATA: shift_en = bit_end;
      STOP: begin
        push_req  = bit_end && rx_s2;
        frame_err = bit_end && !rx_s2;
      end
      default: ;
    endcase
  end

  // prescaler, tick/bit counters and shift register; rate frozen per frame
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      presc    <= '0;
      div_q    <= PW'(DIV_SLOW);
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (state == IDLE) begin
      presc    <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      if (fall) div_q <= i_baud ? PW'(DIV_FAST) : PW'(DIV_SLOW);
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (state == START && mid_hit) tick_cnt <= '0;
        else                           tick_cnt <= tick_cnt + TW'(1);
      end
      if (shift_en) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (push_req),
    .i_data    (shreg),
    .i_pop     (i_read),
    .o_data    (head),
    .o_empty   (empty),
    .o_full    (full),
    .o_push_ok (push_ok),
    .o_pop_ok  (pop_ok)
  );

  assign lf_inc = push_ok && (shreg == LF);
  assign lf_dec = pop_ok && (head == LF);

  // count of LF bytes currently held
  always_ff @(posedge i_clk) begin
    if (!i_rst)                 lf_cnt <= '0;
    else if (lf_inc && !lf_dec) lf_cnt <= lf_cnt + (AW+1)'(1);
    else if (lf_dec && !lf_inc) lf_cnt <= lf_cnt - (AW+1)'(1);
  end

  // registered error pulse: bad stop bit or byte dropped on full
  always_ff @(posedge i_clk) begin
    if (!i_rst) err_q <= 1'b0;
    else        err_q <= frame_err || (push_req && !push_ok);
  end

  assign o_D     = head;
  assign o_ready = !empty;
  assign o_full  = full;
  assign o_used  = (lf_cnt != '0);
  assign o_err   = err_q;

endmodule
